// File: rtl/ysyx_22040759_wb_arbiter_pkg.sv
// Shared sizing and requester encoding for the GPR writeback arbiter and its scoreboard.
package ysyx_22040759_wb_arbiter_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = $clog2(NREG);

  localparam logic REQ_EXU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/ysyx_22040759_scoreboard.sv
// Busy-bit scoreboard: set at accepted issue, cleared at writeback, feeds the IDU hazard stall.
module ysyx_22040759_scoreboard
  import ysyx_22040759_wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid_i,
  input  logic              iss_wr_i,
  input  logic [REG_AW-1:0] iss_rd_i,
  input  logic [REG_AW-1:0] iss_rs1_i,
  input  logic [REG_AW-1:0] iss_rs2_i,
  output logic              iss_stall_o,
  input  logic              wb_fire_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output logic              wb_err_o
);

  logic [NREG-1:1] busy_q, busy_d;
  logic [NREG-1:0] busy_vec;
  logic            wb_err_q, wb_err_d;
  logic            iss_accept;
  logic            wb_clear;

  // x0 is tied off so lookups never need a special case.
  assign busy_vec = {busy_q, 1'b0};

  assign iss_stall_o = busy_vec[iss_rs1_i] | busy_vec[iss_rs2_i] |
                       (iss_wr_i & busy_vec[iss_rd_i]);

  assign iss_accept = iss_valid_i & ~iss_stall_o & iss_wr_i & (iss_rd_i != '0);
  assign wb_clear   = wb_fire_i & (wb_rd_i != '0);

  // Set is applied after clear so a same-cycle issue to the written register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (wb_clear && (wb_rd_i == REG_AW'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (iss_accept && (iss_rd_i == REG_AW'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  assign wb_err_d = wb_err_q | (wb_clear & ~busy_vec[wb_rd_i]);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign wb_err_o = wb_err_q;

endmodule

// File: rtl/ysyx_22040759_wb_arbiter.sv
// Round-robin arbitration of EXU/LSU writebacks onto the single GPR write port.
module ysyx_22040759_wb_arbiter
  import ysyx_22040759_wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid_i,
  input  logic              iss_wr_i,
  input  logic [REG_AW-1:0] iss_rd_i,
  input  logic [REG_AW-1:0] iss_rs1_i,
  input  logic [REG_AW-1:0] iss_rs2_i,
  output logic              iss_stall_o,
  input  logic              exu_valid_i,
  input  logic [REG_AW-1:0] exu_rd_i,
  input  logic [XLEN-1:0]   exu_data_i,
  output logic              exu_ready_o,
  input  logic              lsu_valid_i,
  input  logic [REG_AW-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]   lsu_data_i,
  output logic              lsu_ready_o,
  output logic              gpr_wen_o,
  output logic [REG_AW-1:0] gpr_waddr_o,
  output logic [XLEN-1:0]   gpr_wdata_o,
  output logic              wb_err_o
);

  logic last_grant_q, last_grant_d;
  logic gnt_exu, gnt_lsu;
  logic wb_fire;

  // Grant depends only on valids and last_grant, so a held request is never revoked.
  always_comb begin
    gnt_exu = 1'b0;
    gnt_lsu = 1'b0;
    if (!rst) begin
      if (exu_valid_i && lsu_valid_i) begin
        if (last_grant_q == REQ_LSU) begin
          gnt_exu = 1'b1;
        end else begin
          gnt_lsu = 1'b1;
        end
      end else begin
        gnt_exu = exu_valid_i;
        gnt_lsu = lsu_valid_i;
      end
    end
  end

  assign exu_ready_o = gnt_exu;
  assign lsu_ready_o = gnt_lsu;
  assign wb_fire     = gnt_exu | gnt_lsu;

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_exu) begin
      last_grant_d = REQ_EXU;
    end else if (gnt_lsu) begin
      last_grant_d = REQ_LSU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REQ_LSU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    gpr_waddr_o = '0;
    gpr_wdata_o = '0;
    if (gnt_exu) begin
      gpr_waddr_o = exu_rd_i;
      gpr_wdata_o = exu_data_i;
    end else if (gnt_lsu) begin
      gpr_waddr_o = lsu_rd_i;
      gpr_wdata_o = lsu_data_i;
    end
  end

  // A handshake to x0 is consumed without touching the register file.
  assign gpr_wen_o = wb_fire & (gpr_waddr_o != '0);

  ysyx_22040759_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .iss_valid_i (iss_valid_i),
    .iss_wr_i    (iss_wr_i),
    .iss_rd_i    (iss_rd_i),
    .iss_rs1_i   (iss_rs1_i),
    .iss_rs2_i   (iss_rs2_i),
    .iss_stall_o (iss_stall_o),
    .wb_fire_i   (wb_fire),
    .wb_rd_i     (gpr_waddr_o),
    .wb_err_o    (wb_err_o)
  );

endmodule

// File: tb/tb_ysyx_22040759_wb_arbiter.sv
// Directed bench for the writeback arbiter with a per-cycle reference model of busy/grant/error.
module tb_ysyx_22040759_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_wr, iss_stall;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        exu_valid, lsu_valid, exu_ready, lsu_ready;
  logic [4:0]  exu_rd, lsu_rd, gpr_waddr;
  logic [31:0] exu_data, lsu_data, gpr_wdata;
  logic        gpr_wen, wb_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference state: busy flags per register, who was granted last (1 = LSU), sticky error.
  bit m_busy [32];
  bit m_last;
  bit m_err;

  always #5 clk = ~clk;

  ysyx_22040759_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .iss_valid_i (iss_valid),
    .iss_wr_i    (iss_wr),
    .iss_rd_i    (iss_rd),
    .iss_rs1_i   (iss_rs1),
    .iss_rs2_i   (iss_rs2),
    .iss_stall_o (iss_stall),
    .exu_valid_i (exu_valid),
    .exu_rd_i    (exu_rd),
    .exu_data_i  (exu_data),
    .exu_ready_o (exu_ready),
    .lsu_valid_i (lsu_valid),
    .lsu_rd_i    (lsu_rd),
    .lsu_data_i  (lsu_data),
    .lsu_ready_o (lsu_ready),
    .gpr_wen_o   (gpr_wen),
    .gpr_waddr_o (gpr_waddr),
    .gpr_wdata_o (gpr_wdata),
    .wb_err_o    (wb_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model evaluation on the falling edge: inputs are stable, outputs have settled.
  always @(negedge clk) begin
    bit e_stall, g_exu, g_lsu, fire;
    int w_rd;
    int unsigned w_data;
    e_stall = m_busy[iss_rs1] || m_busy[iss_rs2] || (iss_wr && m_busy[iss_rd]);
    g_exu = 1'b0;
    g_lsu = 1'b0;
    if (!rst) begin
      if (exu_valid && lsu_valid) begin
        g_exu = m_last;
        g_lsu = !m_last;
      end else begin
        g_exu = exu_valid;
        g_lsu = lsu_valid;
      end
    end
    fire   = g_exu || g_lsu;
    w_rd   = g_exu ? int'(exu_rd) : (g_lsu ? int'(lsu_rd) : 0);
    w_data = g_exu ? exu_data : (g_lsu ? lsu_data : 32'd0);
    if (chk_en) begin
      chk("m_stall", {31'd0, iss_stall}, {31'd0, e_stall});
      chk("m_exu_ready", {31'd0, exu_ready}, {31'd0, g_exu});
      chk("m_lsu_ready", {31'd0, lsu_ready}, {31'd0, g_lsu});
      chk("m_wen", {31'd0, gpr_wen}, {31'd0, fire && w_rd != 0});
      chk("m_waddr", {27'd0, gpr_waddr}, w_rd);
      chk("m_wdata", gpr_wdata, w_data);
      chk("m_wb_err", {31'd0, wb_err}, {31'd0, m_err});
    end
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_last = 1'b1;
      m_err  = 1'b0;
    end else begin
      if (fire && w_rd != 0) begin
        if (!m_busy[w_rd]) m_err = 1'b1;
        m_busy[w_rd] = 1'b0;
      end
      if (iss_valid && !e_stall && iss_wr && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      if (fire) m_last = g_lsu;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input logic [4:0] r);
    iss_valid = 1'b0;
    iss_wr    = 1'b0;
    iss_rs1   = r;
    iss_rs2   = 5'd0;
    iss_rd    = 5'd0;
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1'b1;
    iss_wr    = 1'b1;
    iss_rd    = rd;
    iss_rs1   = 5'd0;
    iss_rs2   = 5'd0;
  endtask

  initial begin
    rst = 1'b1;
    iss_valid = 1'b0; iss_wr = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
    exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    step(); step();
    chk_en = 1'b1;
    rst = 1'b0;

    // Reset state
    iss_rs1 = 5'd5; iss_rs2 = 5'd6; iss_rd = 5'd7; iss_wr = 1'b1;
    #2;
    chk("rst_stall", {31'd0, iss_stall}, 32'd0);
    chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
    chk("rst_wen", {31'd0, gpr_wen}, 32'd0);
    for (int r = 1; r < 32; r++) begin
      step();
      probe(5'(r));
      #2;
      chk("rst_busy", {31'd0, iss_stall}, 32'd0);
    end

    // Issue x5, dependent read stalls, EXU writes back, stall drops
    step(); issue(5'd5); #2;
    chk("x5_issue_stall", {31'd0, iss_stall}, 32'd0);
    step(); issue(5'd6); iss_rs1 = 5'd5; #2;
    chk("x5_raw_stall", {31'd0, iss_stall}, 32'd1);
    step(); exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF; #2;
    chk("x5_exu_ready", {31'd0, exu_ready}, 32'd1);
    chk("x5_wen", {31'd0, gpr_wen}, 32'd1);
    chk("x5_waddr", {27'd0, gpr_waddr}, 32'd5);
    chk("x5_wdata", gpr_wdata, 32'hDEADBEEF);
    chk("x5_stall_same_cycle", {31'd0, iss_stall}, 32'd1);
    step(); exu_valid = 1'b0; #2;
    chk("x5_stall_drop", {31'd0, iss_stall}, 32'd0);

    // x0 writeback from LSU
    step(); probe(5'd0); lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0000_1234; #2;
    chk("x0_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    chk("x0_wen", {31'd0, gpr_wen}, 32'd0);
    step(); lsu_valid = 1'b0; issue(5'd3); #2;
    chk("x0_wb_err", {31'd0, wb_err}, 32'd0);

    // Contention: EXU rd3 vs LSU rd4, re-issuing so every writeback hits a busy register
    step(); issue(5'd4);
    step(); probe(5'd0);
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'hA1;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hB1; #2;
    chk("ct1_exu_ready", {31'd0, exu_ready}, 32'd1);
    chk("ct1_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    step(); exu_data = 32'hA2; issue(5'd3); #2;
    chk("ct2_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    chk("ct2_wdata", gpr_wdata, 32'hB1);
    step(); lsu_data = 32'hB2; issue(5'd4); #2;
    chk("ct3_exu_ready", {31'd0, exu_ready}, 32'd1);
    chk("ct3_wdata", gpr_wdata, 32'hA2);
    step(); exu_valid = 1'b0; probe(5'd0); #2;
    chk("ct4_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    step(); lsu_valid = 1'b0; #2;
    chk("ct_wb_err", {31'd0, wb_err}, 32'd0);

    // WAW on x8: issue held through the writeback cycle, accepted once stall releases
    step(); issue(5'd8);
    step(); exu_valid = 1'b1; exu_rd = 5'd8; exu_data = 32'hC8; #2;
    chk("waw_stall", {31'd0, iss_stall}, 32'd1);
    chk("waw_exu_ready", {31'd0, exu_ready}, 32'd1);
    step(); exu_valid = 1'b0; #2;
    chk("waw_release", {31'd0, iss_stall}, 32'd0);
    step(); probe(5'd8); #2;
    chk("waw_busy8", {31'd0, iss_stall}, 32'd1);
    step(); exu_valid = 1'b1; exu_rd = 5'd8; exu_data = 32'hC9;
    step(); exu_valid = 1'b0;

    // Writeback to idle x9 flags the error but still writes
    step(); exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h99; #2;
    chk("err_wen", {31'd0, gpr_wen}, 32'd1);
    chk("err_waddr", {27'd0, gpr_waddr}, 32'd9);
    chk("err_pre", {31'd0, wb_err}, 32'd0);
    // Same-cycle clear and set on x10: set must win
    step(); exu_valid = 1'b0; issue(5'd10);
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'h10; #2;
    chk("err_sticky", {31'd0, wb_err}, 32'd1);
    chk("col_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    step(); lsu_valid = 1'b0; probe(5'd10); #2;
    chk("col_busy10", {31'd0, iss_stall}, 32'd1);

    // Mid-operation reset with x2 busy and a pending EXU request
    step(); issue(5'd2);
    step(); probe(5'd2); rst = 1'b1; exu_valid = 1'b1; exu_rd = 5'd2; exu_data = 32'h22; #2;
    chk("mrst_exu_ready", {31'd0, exu_ready}, 32'd0);
    chk("mrst_wen", {31'd0, gpr_wen}, 32'd0);
    step(); #2;
    chk("mrst_stall", {31'd0, iss_stall}, 32'd0);
    chk("mrst_wb_err", {31'd0, wb_err}, 32'd0);
    chk("mrst_wdata", gpr_wdata, 32'd0);
    step(); rst = 1'b0; exu_valid = 1'b0; probe(5'd10); #2;
    chk("post_rst_busy10", {31'd0, iss_stall}, 32'd0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
